// File: rtl/seg7_scan_4.sv
// seg7_scan_4: double-buffered 4-digit multiplexed 7-segment driver with internal BCD decode.
// Define SCAN_LZB_EN to blank leading zeros on digits 3..1.
module seg7_scan_4 #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [15:0] iBcd,
  input  logic [3:0]  iDp,
  input  logic        iLoad,
  output logic [6:0]  oSeg,
  output logic        oDp,
  output logic [3:0]  oAn,
  output logic        oTick
);
  localparam int RW = $clog2(REFRESH_DIV);
  logic [RW-1:0] rc;
  logic [1:0] idx;
  logic [15:0] pend_bcd, act_bcd;
  logic [3:0] pend_dp, act_dp, dig;
  logic pend_flag, frame_q, wrap, frame, blank;
  logic [6:0] seg;
  assign wrap = rc == RW'(REFRESH_DIV - 1);
  assign frame = wrap && idx == 2'd3;
  assign dig = act_bcd[{idx, 2'b00} +: 4];
`ifdef SCAN_LZB_EN
  logic b3, b2, b1;
  assign b3 = act_bcd[15:12] == 4'd0;
  assign b2 = b3 && act_bcd[11:8] == 4'd0;
  assign b1 = b2 && act_bcd[7:4] == 4'd0;
  assign blank = idx == 2'd3 ? b3 : idx == 2'd2 ? b2 : idx == 2'd1 ? b1 : 1'b0;
`else
  assign blank = 1'b0;
`endif
  always_comb begin
    seg = 7'h3F;
    case (dig)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h3F;
    endcase
  end
  // A load on the frame edge bypasses pending so the newest value wins.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rc <= '0;
      idx <= 2'd0;
      pend_bcd <= 16'h0;
      pend_dp <= 4'h0;
      act_bcd <= 16'h0;
      act_dp <= 4'h0;
      pend_flag <= 1'b0;
      frame_q <= 1'b0;
      oSeg <= 7'h7F;
      oDp <= 1'b1;
      oAn <= 4'hF;
      oTick <= 1'b0;
    end else begin
      rc <= wrap ? '0 : rc + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      if (frame && iLoad) begin
        act_bcd <= iBcd;
        act_dp <= iDp;
        pend_flag <= 1'b0;
      end else if (frame && pend_flag) begin
        act_bcd <= pend_bcd;
        act_dp <= pend_dp;
        pend_flag <= 1'b0;
      end else if (iLoad) begin
        pend_bcd <= iBcd;
        pend_dp <= iDp;
        pend_flag <= 1'b1;
      end
      frame_q <= frame;
      oTick <= frame_q;
      oAn <= ~(4'b0001 << idx);
      oSeg <= blank ? 7'h7F : seg;
      oDp <= ~act_dp[idx];
    end
  end
endmodule

// File: tb/tb_seg7_scan_4.sv
// tb_seg7_scan_4: directed self-checking bench for seg7_scan_4 with REFRESH_DIV=4.
module tb_seg7_scan_4;
  localparam int RD = 4;
  logic CLK = 1'b0;
  logic rst = 1'b1;
  logic [15:0] iBcd = 16'h0;
  logic [3:0] iDp = 4'h0;
  logic iLoad = 1'b0;
  logic [6:0] oSeg;
  logic oDp;
  logic [3:0] oAn;
  logic oTick;
  int tests = 0;
  int fails = 0;
`ifdef SCAN_LZB_EN
  localparam logic [6:0] ZB = 7'h7F;
`else
  localparam logic [6:0] ZB = 7'h40;
`endif

  seg7_scan_4 #(.REFRESH_DIV(RD)) dut (
    .CLK(CLK), .rst(rst), .iBcd(iBcd), .iDp(iDp), .iLoad(iLoad),
    .oSeg(oSeg), .oDp(oDp), .oAn(oAn), .oTick(oTick)
  );

  always #5 CLK = ~CLK;

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!oTick && n < 100);
    tests++;
    if (oTick !== 1'b1) begin
      fails++;
      $display("FAIL frame_wait: oTick=%b after %0d cycles, want 1", oTick, n);
    end
  endtask

  task automatic load(input logic [15:0] b, input logic [3:0] d);
    iBcd = b;
    iDp = d;
    iLoad = 1'b1;
    @(negedge CLK);
    iLoad = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    tests++; if (oAn !== 4'hF) begin fails++; $display("FAIL reset_an: got %h want f", oAn); end
    tests++; if (oSeg !== 7'h7F) begin fails++; $display("FAIL reset_seg: got %h want 7f", oSeg); end
    tests++; if (oDp !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b want 1", oDp); end
    tests++; if (oTick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", oTick); end
    rst = 1'b0;
    @(negedge CLK);
    tests++; if (oAn !== 4'hE) begin fails++; $display("FAIL release_an: got %h want e", oAn); end
    tests++; if (oSeg !== 7'h40) begin fails++; $display("FAIL release_seg: got %h want 40", oSeg); end
    tests++; if (oTick !== 1'b0) begin fails++; $display("FAIL release_tick: got %b want 0", oTick); end
  endtask

  task automatic test_cadence();
    logic [3:0] ea;
    logic et;
    for (int c = 2; c <= 40; c++) begin
      @(negedge CLK);
      ea = 4'hF;
      ea[((c - 1) / 4) % 4] = 1'b0;
      et = (c - 1) % 16 == 0;
      tests++; if (oAn !== ea) begin fails++; $display("FAIL cadence_an c=%0d: got %h want %h", c, oAn, ea); end
      tests++; if (oTick !== et) begin fails++; $display("FAIL cadence_tick c=%0d: got %b want %b", c, oTick, et); end
    end
  endtask

  task automatic test_double_buffer();
    logic [6:0] e [4];
    logic [6:0] es;
    logic [3:0] ea;
    int n = 0;
    e = '{7'h19, 7'h30, 7'h24, 7'h79};
    wait_frame();
    repeat (5) @(negedge CLK);
    load(16'h1234, 4'b0001);
    while (!oTick && n < 40) begin
      es = oAn == 4'hE ? 7'h40 : ZB;
      tests++; if (oSeg !== es) begin fails++; $display("FAIL db_old_seg an=%h: got %h want %h", oAn, oSeg, es); end
      tests++; if (oDp !== 1'b1) begin fails++; $display("FAIL db_old_dp an=%h: got %b want 1", oAn, oDp); end
      @(negedge CLK);
      n++;
    end
    tests++; if (oTick !== 1'b1) begin fails++; $display("FAIL db_boundary: oTick=%b want 1", oTick); end
    for (int i = 0; i < 16; i++) begin
      ea = 4'hF;
      ea[i / 4] = 1'b0;
      tests++; if (oAn !== ea) begin fails++; $display("FAIL db_an i=%0d: got %h want %h", i, oAn, ea); end
      tests++; if (oSeg !== e[i / 4]) begin fails++; $display("FAIL db_seg i=%0d: got %h want %h", i, oSeg, e[i / 4]); end
      tests++; if (oDp !== (i >= 4)) begin fails++; $display("FAIL db_dp i=%0d: got %b want %b", i, oDp, i >= 4); end
      @(negedge CLK);
    end
  endtask

  task automatic test_simultaneous();
    wait_frame();
    load(16'h1111, 4'hF);
    repeat (13) @(negedge CLK);
    iBcd = 16'h9999;
    iDp = 4'h0;
    iLoad = 1'b1;
    @(negedge CLK);
    iLoad = 1'b0;
    tests++; if (oAn !== 4'h7) begin fails++; $display("FAIL sim_last_an: got %h want 7", oAn); end
    tests++; if (oSeg !== 7'h79) begin fails++; $display("FAIL sim_last_seg: got %h want 79", oSeg); end
    @(negedge CLK);
    tests++; if (oTick !== 1'b1) begin fails++; $display("FAIL sim_tick: got %b want 1", oTick); end
    for (int i = 0; i < 32; i++) begin
      tests++; if (oSeg !== 7'h10) begin fails++; $display("FAIL sim_seg i=%0d: got %h want 10", i, oSeg); end
      tests++; if (oDp !== 1'b1) begin fails++; $display("FAIL sim_dp i=%0d: got %b want 1", i, oDp); end
      @(negedge CLK);
    end
  endtask

  task automatic test_lzb();
    logic [6:0] e [4];
    wait_frame();
    load(16'h00AF, 4'h0);
    wait_frame();
    e = '{7'h3F, 7'h3F, ZB, ZB};
    for (int i = 0; i < 16; i++) begin
      tests++; if (oSeg !== e[i / 4]) begin fails++; $display("FAIL lzb_00af i=%0d: got %h want %h", i, oSeg, e[i / 4]); end
      @(negedge CLK);
    end
    load(16'h0201, 4'h0);
    wait_frame();
    e = '{7'h79, 7'h40, 7'h24, ZB};
    for (int i = 0; i < 16; i++) begin
      tests++; if (oSeg !== e[i / 4]) begin fails++; $display("FAIL lzb_0201 i=%0d: got %h want %h", i, oSeg, e[i / 4]); end
      @(negedge CLK);
    end
    load(16'h0000, 4'h0);
    wait_frame();
    e = '{7'h40, ZB, ZB, ZB};
    for (int i = 0; i < 16; i++) begin
      tests++; if (oSeg !== e[i / 4]) begin fails++; $display("FAIL lzb_0000 i=%0d: got %h want %h", i, oSeg, e[i / 4]); end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e [4];
    e = '{7'h02, 7'h12, 7'h19, 7'h30};
    iLoad = 1'b1;
    iBcd = 16'h1111;
    @(negedge CLK);
    iBcd = 16'h2222;
    @(negedge CLK);
    iBcd = 16'h3456;
    @(negedge CLK);
    iLoad = 1'b0;
    wait_frame();
    for (int i = 0; i < 16; i++) begin
      tests++; if (oSeg !== e[i / 4]) begin fails++; $display("FAIL held_load i=%0d: got %h want %h", i, oSeg, e[i / 4]); end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] e [3];
    logic [6:0] es;
    e = '{7'h00, 7'h78, 7'h02};
    load(16'h5678, 4'h0);
    wait_frame();
    for (int j = 0; j < 10; j++) begin
      tests++; if (oSeg !== e[j / 4]) begin fails++; $display("FAIL mid_pre j=%0d: got %h want %h", j, oSeg, e[j / 4]); end
      if (j < 9) @(negedge CLK);
    end
    tests++; if (oAn !== 4'hB) begin fails++; $display("FAIL mid_pre_an: got %h want b", oAn); end
    #2 rst = 1'b1;
    #1;
    tests++; if (oAn !== 4'hF) begin fails++; $display("FAIL mid_rst_an: got %h want f", oAn); end
    tests++; if (oSeg !== 7'h7F) begin fails++; $display("FAIL mid_rst_seg: got %h want 7f", oSeg); end
    tests++; if (oDp !== 1'b1) begin fails++; $display("FAIL mid_rst_dp: got %b want 1", oDp); end
    tests++; if (oTick !== 1'b0) begin fails++; $display("FAIL mid_rst_tick: got %b want 0", oTick); end
    @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    tests++; if (oAn !== 4'hE) begin fails++; $display("FAIL mid_rel_an: got %h want e", oAn); end
    for (int i = 0; i < 16; i++) begin
      es = i < 4 ? 7'h40 : ZB;
      tests++; if (oSeg !== es) begin fails++; $display("FAIL mid_rel_seg i=%0d: got %h want %h", i, oSeg, es); end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_double_buffer();
    test_simultaneous();
    test_lzb();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
